// File: rtl/flash_arb_pkg.sv
// Shared constants and state encoding for the two-port flash read arbiter.
package flash_arb_pkg;
  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } flash_st_e;
endpackage

// File: rtl/flash_rr_pick.sv
// Two-request round-robin pick: on contention the requester that did not win last time goes.
module flash_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);
  assign gnt0 = req0 & (~req1 | last_grant);
  assign gnt1 = req1 & (~req0 | ~last_grant);
endmodule

// File: rtl/flash_arbiter.sv
// Arbitrates two read ports onto one Avalon-MM flash slave, one read outstanding at a time.
// Optional watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W      = FLASH_ADDR_W,
  parameter int DATA_W      = FLASH_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_ack,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  output logic              rd0_err,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_ack,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  output logic              rd1_err,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic              flash_mem_write,
  output logic [6:0]        flash_mem_burstcount,
  output logic [3:0]        flash_mem_byteenable,
  output logic [DATA_W-1:0] flash_mem_writedata
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT_DATA;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              last_grant;
  logic              gnt0, gnt1;
  logic              idle_ok;
  logic              tmo;
  logic              fin;
  logic [DATA_W-1:0] fin_data;

  flash_rr_pick u_pick (
    .req0       (rd0_req),
    .req1       (rd1_req),
    .last_grant (last_grant),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // A grant is held off while a valid pulse is out, so the next one lands the cycle after.
  assign idle_ok = (state == ST_IDLE) & ~rd0_valid & ~rd1_valid & ~rst;
  assign rd0_ack = gnt0 & idle_ok;
  assign rd1_ack = gnt1 & idle_ok;

  assign flash_mem_read       = (state == ST_ISSUE);
  assign flash_mem_address    = addr_q;
  assign flash_mem_write      = 1'b0;
  assign flash_mem_burstcount = 7'd1;
  assign flash_mem_byteenable = 4'hF;
  assign flash_mem_writedata  = '0;

  // Slave data wins over a watchdog expiry landing in the same cycle.
  assign fin      = ((state == ST_WAIT) & flash_mem_readdatavalid) | tmo;
  assign fin_data = ((state == ST_WAIT) & flash_mem_readdatavalid) ? flash_mem_readdata
                                                                   : DATA_W'(TIMEOUT_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      last_grant <= 1'b1;
      rd0_valid  <= 1'b0;
      rd1_valid  <= 1'b0;
      rd0_data   <= '0;
      rd1_data   <= '0;
    end else begin
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
      case (state)
        ST_IDLE: if (rd0_ack | rd1_ack) begin
          addr_q     <= rd1_ack ? rd1_addr : rd0_addr;
          last_grant <= rd1_ack;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: if (!flash_mem_waitrequest) state <= ST_WAIT;
        ST_WAIT:  ;
        default:  state <= ST_IDLE;
      endcase
      if (fin) begin
        state <= ST_IDLE;
        if (last_grant) begin
          rd1_data  <= fin_data;
          rd1_valid <= 1'b1;
        end else begin
          rd0_data  <= fin_data;
          rd0_valid <= 1'b1;
        end
      end
    end
  end

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts cycles spent in ISSUE/WAIT_DATA; expires on the TIMEOUT_CYC-th such cycle.
  assign tmo = (state != ST_IDLE) & (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      rd0_err <= 1'b0;
      rd1_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_IDLE) ? '0 : tmo_cnt + 1'b1;
      rd0_err <= tmo & ~last_grant;
      rd1_err <= tmo & last_grant;
    end
  end
`else
  assign tmo     = 1'b0;
  assign rd0_err = 1'b0;
  assign rd1_err = 1'b0;
`endif
endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter; define FLASH_ARB_TIMEOUT_EN to also cover the watchdog.
module tb_flash_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd0_req = 1'b0, rd1_req = 1'b0;
  logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
  logic          rd0_ack, rd1_ack, rd0_valid, rd1_valid, rd0_err, rd1_err;
  logic [DW-1:0] rd0_data, rd1_data;
  logic          flash_mem_read, flash_mem_write;
  logic [AW-1:0] flash_mem_address;
  logic          flash_mem_waitrequest = 1'b0;
  logic [DW-1:0] flash_mem_readdata = '0;
  logic          flash_mem_readdatavalid = 1'b0;
  logic [6:0]    flash_mem_burstcount;
  logic [3:0]    flash_mem_byteenable;
  logic [DW-1:0] flash_mem_writedata;

  always #5 clk = ~clk;

  flash_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack), .rd0_data(rd0_data),
    .rd0_valid(rd0_valid), .rd0_err(rd0_err),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack), .rd1_data(rd1_data),
    .rd1_valid(rd1_valid), .rd1_err(rd1_err),
    .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
    .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid), .flash_mem_write(flash_mem_write),
    .flash_mem_burstcount(flash_mem_burstcount), .flash_mem_byteenable(flash_mem_byteenable),
    .flash_mem_writedata(flash_mem_writedata)
  );

  int vec = 0, miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model: wait_n stall cycles per read, data addr*10002 lat_n cycles after accept
  int wait_n = 0, lat_n = 1, accepts = 0;
  bit mute = 1'b0;
  int wcnt = 0, lcnt = 0;
  bit pend = 1'b0;
  logic [AW-1:0] paddr = '0;
  always @(negedge clk) begin
    flash_mem_readdatavalid = 1'b0;
    if (pend) begin
      if (lcnt <= 1) begin
        flash_mem_readdatavalid = !mute;
        flash_mem_readdata      = 32'(paddr) * 32'd10002;
        pend = 1'b0;
      end else lcnt--;
    end
    if (flash_mem_read) begin
      if (wcnt < wait_n) begin
        flash_mem_waitrequest = 1'b1;
        wcnt++;
      end else begin
        flash_mem_waitrequest = 1'b0;
        wcnt = 0; pend = 1'b1; lcnt = lat_n; paddr = flash_mem_address; accepts++;
      end
    end else flash_mem_waitrequest = 1'b0;
  end

  // monitor
  int n_ack0, n_ack1, n_v0, n_v1, n_err0, n_err1, a_cyc, v_cyc, e_cyc, nv, rd_cyc, addr_bad;
  int err_total = 0, static_bad = 0;
  int v_who [8];
  logic [DW-1:0] v_dat [8];
  logic [AW-1:0] exp_addr = '0;

  always @(negedge clk) begin
    if (flash_mem_write !== 1'b0 || flash_mem_burstcount !== 7'd1 ||
        flash_mem_byteenable !== 4'hF || flash_mem_writedata !== '0 ||
        (rd0_valid && rd1_valid)) static_bad++;
    if (rd0_ack) begin n_ack0++; a_cyc = cyc; end
    if (rd1_ack) begin n_ack1++; a_cyc = cyc; end
    if (rd0_valid || rd1_valid) begin
      v_cyc = cyc;
      if (nv < 8) begin
        v_who[nv] = rd1_valid ? 1 : 0;
        v_dat[nv] = rd1_valid ? rd1_data : rd0_data;
      end
      nv++;
    end
    if (rd0_valid) n_v0++;
    if (rd1_valid) n_v1++;
    if (rd0_err) begin n_err0++; e_cyc = cyc; err_total++; end
    if (rd1_err) begin n_err1++; e_cyc = cyc; err_total++; end
    if (flash_mem_read) begin
      rd_cyc++;
      if (flash_mem_address !== exp_addr) addr_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_ack0 = 0; n_ack1 = 0; n_v0 = 0; n_v1 = 0; n_err0 = 0; n_err1 = 0;
    a_cyc = 0; v_cyc = 0; e_cyc = 0; nv = 0; rd_cyc = 0; addr_bad = 0; accepts = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    // reset state
    tick(3);
    chk("rst_ack_valid", {rd0_ack, rd1_ack, rd0_valid, rd1_valid, rd0_err, rd1_err}, 0);
    chk("rst_read", flash_mem_read, 0);
    chk("rst_data0", rd0_data, 0);
    chk("rst_data1", rd1_data, 0);
    chk("rst_addr", flash_mem_address, 0);
    rst = 1'b0;
    tick(2);

    // single read on port 0, request dropped right after ack
    clr(); exp_addr = 5; rd0_addr = 5; rd0_req = 1'b1;
    tick(1); rd0_req = 1'b0;
    tick(8);
    chk("single_ack0", n_ack0, 1);
    chk("single_v0", n_v0, 1);
    chk("single_data0", rd0_data, 50010);
    chk("single_lat", v_cyc - a_cyc, 3);
    chk("single_port1_idle", n_ack1 + n_v1, 0);
    chk("single_data1", rd1_data, 0);
    chk("single_accepts", accepts, 1);

    // waitrequest held 3 cycles on a port 1 read
    clr(); wait_n = 3; exp_addr = 7; rd1_addr = 7; rd1_req = 1'b1;
    tick(1); rd1_req = 1'b0;
    tick(10); wait_n = 0;
    chk("wait_read_cycles", rd_cyc, 4);
    chk("wait_addr_stable", addr_bad, 0);
    chk("wait_accepts", accepts, 1);
    chk("wait_v1", n_v1, 1);
    chk("wait_data1", rd1_data, 70014);
    chk("wait_lat", v_cyc - a_cyc, 6);
    chk("wait_data0_held", rd0_data, 50010);

    // contention from reset
    rst = 1'b1; rd0_addr = 1; rd1_addr = 2; rd0_req = 1'b1; rd1_req = 1'b1;
    clr();
    tick(2);
    chk("cont_ack_in_rst", n_ack0 + n_ack1, 0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (nv >= 3) break;
    end
    rd0_req = 1'b0; rd1_req = 1'b0;
    tick(8);
    chk("cont_count", nv, 3);
    chk("cont_who0", v_who[0], 0);
    chk("cont_dat0", v_dat[0], 10002);
    chk("cont_who1", v_who[1], 1);
    chk("cont_dat1", v_dat[1], 20004);
    chk("cont_who2", v_who[2], 0);
    chk("cont_dat2", v_dat[2], 10002);

    // reset during WAIT_DATA, slave data arrives after release
    clr(); lat_n = 4; rd0_addr = 3; rd0_req = 1'b1;
    tick(1); rd0_req = 1'b0;
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0;
    tick(8); lat_n = 1;
    chk("rstmid_accepts", accepts, 1);
    chk("rstmid_no_valid", n_v0 + n_v1, 0);
    chk("rstmid_data0", rd0_data, 0);
    chk("rstmid_data1", rd1_data, 0);
    clr(); rd1_addr = 9; rd1_req = 1'b1;
    tick(1); rd1_req = 1'b0;
    tick(8);
    chk("after_rst_v1", n_v1, 1);
    chk("after_rst_v0", n_v0, 0);
    chk("after_rst_data1", rd1_data, 90018);

`ifdef FLASH_ARB_TIMEOUT_EN
    // slave never answers; watchdog of 8 cycles completes the read
    clr(); mute = 1'b1; rd0_addr = 4; rd0_req = 1'b1;
    tick(1); rd0_req = 1'b0;
    tick(14); mute = 1'b0;
    chk("tmo_err0", n_err0, 1);
    chk("tmo_err1", n_err1, 0);
    chk("tmo_v0", n_v0, 1);
    chk("tmo_data0", rd0_data, 32'hDEAD_BEEF);
    chk("tmo_lat", v_cyc - a_cyc, 9);
    chk("tmo_err_with_valid", e_cyc, v_cyc);
    clr(); rd1_addr = 2; rd1_req = 1'b1;
    tick(1); rd1_req = 1'b0;
    tick(8);
    chk("post_tmo_v1", n_v1, 1);
    chk("post_tmo_data1", rd1_data, 20004);
    chk("post_tmo_no_err", n_err0 + n_err1, 0);
`else
    chk("no_err_ever", err_total, 0);
`endif

    chk("static_outputs", static_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
